// File: rtl/wb_counter_pkg.sv
// Shared constants for the Wishbone counter port: register map, bit positions, reset values
// and the byte-lane write merge used by every writable register.
package wb_counter_pkg;

  localparam logic [4:0] OffCtrl     = 5'h00;
  localparam logic [4:0] OffCount    = 5'h04;
  localparam logic [4:0] OffLimit    = 5'h08;
  localparam logic [4:0] OffStatus   = 5'h0C;
  localparam logic [4:0] OffPrescale = 5'h10;

  localparam int unsigned CtrlEn    = 0;
  localparam int unsigned CtrlDown  = 1;
  localparam int unsigned CtrlOe    = 2;
  localparam int unsigned CtrlIrqen = 3;

  localparam int unsigned StatusWrap = 0;
  localparam int unsigned StatusEn   = 1;

  localparam logic [3:0]  CtrlRst  = 4'h0;
  localparam logic [31:0] LimitRst = 32'hFFFF_FFFF;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_counter_tick.sv
// Prescaler: counts 0..prescale while enabled and emits a one-cycle tick on the terminal value.
module wb_counter_tick #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  load,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == prescale);

  always_comb begin
    if (!en || load || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_counter_port.sv
// Wishbone-classic slave holding a prescaled up/down counter with limit, sticky wrap flag and
// interrupt; the count is driven straight onto the user IO pads.
module wb_counter_port
  import wb_counter_pkg::*;
#(
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             resetb,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oeb,
  output logic             irq_o
);

  logic                  ack_q;
  logic [31:0]           dat_q;
  logic [3:0]            ctrl_q, ctrl_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      limit_q, limit_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  wrap_q, wrap_d;
  logic                  irq_q;

  logic        hit, access, wr, rd;
  logic [4:0]  off;
  logic        tick, at_end, wrap_set, wrap_clr;
  logic        count_wr, prescale_wr;
  logic [31:0] ctrl_m, count_m, limit_m, prescale_m, rdata;
  logic        unused_bits;

  assign off    = wbs_adr_i[4:0];
  assign hit    = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:5] == BASE_ADR[31:5]);
  // The write commits on the same edge that raises ack, so an aborted cycle changes nothing.
  assign access = hit && !ack_q;
  assign wr     = access && wbs_we_i;
  assign rd     = access && !wbs_we_i;

  assign count_wr    = wr && (off == OffCount);
  assign prescale_wr = wr && (off == OffPrescale);
  assign wrap_clr    = wr && (off == OffStatus) && wbs_sel_i[0] && wbs_dat_i[StatusWrap];

  wb_counter_tick #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick (
    .clock   (wb_clk_i),
    .resetb  (resetb),
    .en      (ctrl_q[CtrlEn]),
    .prescale(prescale_q),
    .load    (prescale_wr),
    .tick    (tick)
  );

  always_comb begin
    ctrl_m     = merge_bytes(32'(ctrl_q), wbs_dat_i, wbs_sel_i);
    count_m    = merge_bytes(32'(count_q), wbs_dat_i, wbs_sel_i);
    limit_m    = merge_bytes(32'(limit_q), wbs_dat_i, wbs_sel_i);
    prescale_m = merge_bytes(32'(prescale_q), wbs_dat_i, wbs_sel_i);
  end

  assign unused_bits = ^{ctrl_m[31:4], count_m, limit_m, prescale_m};

  always_comb begin
    rdata = '0;
    case (off)
      OffCtrl:     rdata = 32'(ctrl_q);
      OffCount:    rdata = 32'(count_q);
      OffLimit:    rdata = 32'(limit_q);
      OffStatus: begin
        rdata[StatusWrap] = wrap_q;
        rdata[StatusEn]   = ctrl_q[CtrlEn];
      end
      OffPrescale: rdata = 32'(prescale_q);
      default:     rdata = '0;
    endcase
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    limit_d    = limit_q;
    prescale_d = prescale_q;
    if (wr && (off == OffCtrl))     ctrl_d     = ctrl_m[3:0];
    if (wr && (off == OffLimit))    limit_d    = limit_m[WIDTH-1:0];
    if (prescale_wr)                prescale_d = prescale_m[PRESCALE_W-1:0];
  end

  // A software load of COUNT overrides the tick and suppresses any wrap it would cause.
  always_comb begin
    at_end   = ctrl_q[CtrlDown] ? (count_q == '0) : (count_q == limit_q);
    count_d  = count_q;
    wrap_set = 1'b0;
    if (count_wr) begin
      count_d = count_m[WIDTH-1:0];
    end else if (tick) begin
      wrap_set = at_end;
      if (ctrl_q[CtrlDown]) begin
        count_d = at_end ? limit_q : count_q - 1'b1;
      end else begin
        count_d = at_end ? '0 : count_q + 1'b1;
      end
    end
    wrap_d = wrap_set || (wrap_q && !wrap_clr);
  end

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      ctrl_q     <= CtrlRst;
      count_q    <= '0;
      limit_q    <= LimitRst[WIDTH-1:0];
      prescale_q <= '0;
      wrap_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ack_q      <= access;
      if (rd) dat_q <= rdata;
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      prescale_q <= prescale_d;
      wrap_q     <= wrap_d;
      irq_q      <= wrap_q && ctrl_q[CtrlIrqen];
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = count_q;
  assign io_oeb    = {WIDTH{~ctrl_q[CtrlOe]}};
  assign irq_o     = irq_q;

endmodule
